// File: rtl/hex_byte_encoder_if.sv
// Byte-in / digit-words-out bundle between a producer and hex_byte_encoder.
// The slave side is the encoder; the master side is the byte producer plus the display consumer.
interface hex_byte_encoder_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic [1:0]  in_dp;
  logic        in_ready;
  logic [11:0] low;
  logic [11:0] high;

  modport master (
    output in_valid, in_data, in_dp,
    input  in_ready, low, high
  );

  modport slave (
    input  in_valid, in_data, in_dp,
    output in_ready, low, high
  );
endinterface

// File: rtl/hex_byte_encoder.sv
// Encodes one byte into two active-low seven-segment digit words, then holds
// the committed value for HOLD_CYCLES clocks before it accepts the next byte.
module hex_byte_encoder #(
  parameter int HOLD_CYCLES = 4096,
  parameter bit BLANK_LZ    = 1'b0
) (
  input logic              clk,
  input logic              rst_n,
  hex_byte_encoder_if.slave bus
);

  localparam int CW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
  localparam logic [CW-1:0] HOLD_LOAD = (HOLD_CYCLES > 0) ? CW'(HOLD_CYCLES - 1) : '0;

  typedef enum logic [1:0] {IDLE, ENC_LO, ENC_HI, HOLD} state_t;

  state_t      state_q;
  logic [7:0]  data_q;
  logic [1:0]  dp_q;
  logic [11:0] stage_q;
  logic [11:0] low_q;
  logic [11:0] high_q;
  logic [CW-1:0] cnt_q;

  logic        ready;
  logic [6:0]  hi_seg;
  logic [11:0] lo_word_d;
  logic [11:0] hi_word_d;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: seg7 = 7'h40;
      4'h1: seg7 = 7'h79;
      4'h2: seg7 = 7'h24;
      4'h3: seg7 = 7'h30;
      4'h4: seg7 = 7'h19;
      4'h5: seg7 = 7'h12;
      4'h6: seg7 = 7'h02;
      4'h7: seg7 = 7'h78;
      4'h8: seg7 = 7'h00;
      4'h9: seg7 = 7'h10;
      4'hA: seg7 = 7'h08;
      4'hB: seg7 = 7'h03;
      4'hC: seg7 = 7'h46;
      4'hD: seg7 = 7'h21;
      4'hE: seg7 = 7'h06;
      default: seg7 = 7'h0E;
    endcase
  endfunction

  // Word layout: [11:10]=1, [9]=~dp, [8]/[7] digit selects held high, [6:0] segments.
  function automatic logic [11:0] digit_word(input logic [6:0] seg, input logic dp);
    digit_word = {2'b11, ~dp, 2'b11, seg};
  endfunction

  always_comb begin
    hi_seg    = (BLANK_LZ && (data_q[7:4] == 4'h0)) ? 7'h7F : seg7(data_q[7:4]);
    lo_word_d = digit_word(seg7(data_q[3:0]), dp_q[0]);
    hi_word_d = digit_word(hi_seg, dp_q[1]);
  end

  assign ready        = (state_q == IDLE);
  assign bus.in_ready = ready;
  assign bus.low      = low_q;
  assign bus.high     = high_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      dp_q    <= '0;
      stage_q <= '0;
      low_q   <= 12'hFFF;
      high_q  <= 12'hFFF;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid && ready) begin
            data_q  <= bus.in_data;
            dp_q    <= bus.in_dp;
            state_q <= ENC_LO;
          end
        end
        ENC_LO: begin
          stage_q <= lo_word_d;
          state_q <= ENC_HI;
        end
        ENC_HI: begin
          // Both digits land on this one edge so the display never shows a torn byte.
          low_q  <= stage_q;
          high_q <= hi_word_d;
          if (HOLD_CYCLES == 0) begin
            state_q <= IDLE;
          end else begin
            cnt_q   <= HOLD_LOAD;
            state_q <= HOLD;
          end
        end
        HOLD: begin
          if (cnt_q == '0) state_q <= IDLE;
          else             cnt_q   <= cnt_q - 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hex_byte_encoder.sv
// Directed bench: three encoder instances (hold 4 / hold 4 blanked / hold 0) with hand-computed words.
module tb_hex_byte_encoder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  hex_byte_encoder_if b0();
  hex_byte_encoder_if b1();
  hex_byte_encoder_if b2();

  logic       vld = 1'b0;
  logic [7:0] dat = 8'h00;
  logic [1:0] dpr = 2'b00;

  assign b0.in_valid = vld;
  assign b0.in_data  = dat;
  assign b0.in_dp    = dpr;
  assign b1.in_valid = vld;
  assign b1.in_data  = dat;
  assign b1.in_dp    = dpr;

  hex_byte_encoder #(.HOLD_CYCLES(4), .BLANK_LZ(1'b0)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0.slave));
  hex_byte_encoder #(.HOLD_CYCLES(4), .BLANK_LZ(1'b1)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
  hex_byte_encoder #(.HOLD_CYCLES(0), .BLANK_LZ(1'b0)) u2 (.clk(clk), .rst_n(rst_n), .bus(b2.slave));

  int acc0[$];
  int acc2[$];
  int run0 = 0, last_run0 = 0;
  int run2 = 0, last_run2 = 0;
  int chg0 = 0;
  logic [23:0] prev0 = 24'hFFFFFF;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (b0.in_valid && b0.in_ready) acc0.push_back(cyc);
    if (b2.in_valid && b2.in_ready) acc2.push_back(cyc);
  end

  always @(negedge clk) begin
    if (!b0.in_ready) run0 <= run0 + 1;
    else if (run0 != 0) begin
      last_run0 <= run0;
      run0      <= 0;
    end
    if (!b2.in_ready) run2 <= run2 + 1;
    else if (run2 != 0) begin
      last_run2 <= run2;
      run2      <= 0;
    end
    prev0 <= {b0.low, b0.high};
    if ({b0.low, b0.high} != prev0) chg0 <= chg0 + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle0();
    int n;
    n = 0;
    while (!b0.in_ready && n < 100) begin
      step();
      n++;
    end
    check("idle_timeout", (n < 100), 1);
  endtask

  // Leaves the caller one #1 after the accepting edge.
  task automatic send(input logic [7:0] d, input logic [1:0] p);
    wait_idle0();
    vld = 1'b1;
    dat = d;
    dpr = p;
    step();
    vld = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base, c0;
    b2.in_valid = 1'b0;
    b2.in_data  = 8'h00;
    b2.in_dp    = 2'b00;

    repeat (3) step();
    check("rst_low",   b0.low,      12'hFFF);
    check("rst_high",  b0.high,     12'hFFF);
    check("rst_ready", b0.in_ready, 1);
    rst_n = 1'b1;
    step(); step();
    check("idle_low",    b0.low,      12'hFFF);
    check("idle_high",   b1.high,     12'hFFF);
    check("idle_ready2", b2.in_ready, 1);

    // A5: latency two edges, both digits on the same edge
    send(8'hA5, 2'b00);
    check("a5_rdy_e0", b0.in_ready, 0);
    step();
    check("a5_lo_e1", b0.low,  12'hFFF);
    check("a5_hi_e1", b0.high, 12'hFFF);
    step();
    check("a5_lo",    b0.low,  12'hF92);
    check("a5_hi",    b0.high, 12'hF88);
    check("a5_lo_b",  b1.low,  12'hF92);
    check("a5_hi_b",  b1.high, 12'hF88);
    wait_idle0();
    #5;
    check("a5_busy_run", last_run0, 6);

    send(8'h3C, 2'b01);
    step();
    check("3c_lo_e1", b0.low, 12'hF92);
    step();
    check("3c_lo", b0.low,  12'hDC6);
    check("3c_hi", b0.high, 12'hFB0);

    send(8'h07, 2'b00);
    step(); step();
    check("07_lo",       b0.low,  12'hFF8);
    check("07_hi",       b0.high, 12'hFC0);
    check("07_lo_blank", b1.low,  12'hFF8);
    check("07_hi_blank", b1.high, 12'hFFF);

    send(8'h07, 2'b10);
    step(); step();
    check("07dp_hi",       b0.high, 12'hDC0);
    check("07dp_hi_blank", b1.high, 12'hDFF);
    check("07dp_lo_blank", b1.low,  12'hFF8);

    // valid held high with a new byte every cycle
    wait_idle0();
    #5;
    base = acc0.size();
    c0   = chg0;
    step();
    vld = 1'b1;
    dat = 8'h20;
    dpr = 2'b00;
    repeat (29) begin
      step();
      dat = dat + 8'h01;
    end
    vld = 1'b0;
    wait_idle0();
    #5;
    check("stream_accepts", acc0.size() - base, 5);
    for (int i = base + 1; i < acc0.size(); i++) check("stream_gap", acc0[i] - acc0[i-1], 7);
    check("stream_changes", chg0 - c0, 5);
    check("stream_lo", b0.low,  12'hFC6);
    check("stream_hi", b0.high, 12'hFB0);

    // reset while the FF byte sits in ENC_HI
    send(8'hFF, 2'b00);
    step();
    rst_n = 1'b0;
    #1;
    check("abort_lo_now",  b0.low,      12'hFFF);
    check("abort_hi_now",  b0.high,     12'hFFF);
    check("abort_ready",   b0.in_ready, 1);
    step(); step();
    rst_n = 1'b1;
    step(); step();
    check("abort_lo_after", b0.low,      12'hFFF);
    check("abort_hi_after", b0.high,     12'hFFF);
    check("abort_idle",     b0.in_ready, 1);
    send(8'h12, 2'b00);
    step(); step();
    check("12_lo", b0.low,  12'hFA4);
    check("12_hi", b0.high, 12'hFF9);

    // zero hold: busy two cycles, byte period three
    b2.in_valid = 1'b1;
    b2.in_data  = 8'h5A;
    b2.in_dp    = 2'b11;
    step();
    b2.in_valid = 1'b0;
    check("h0_rdy_e0", b2.in_ready, 0);
    step();
    check("h0_rdy_e1", b2.in_ready, 0);
    check("h0_lo_e1",  b2.low,      12'hFFF);
    step();
    check("h0_rdy_e2", b2.in_ready, 1);
    check("h0_lo",     b2.low,      12'hD88);
    check("h0_hi",     b2.high,     12'hD92);
    #5;
    check("h0_busy_run", last_run2, 2);
    base = acc2.size();
    b2.in_valid = 1'b1;
    repeat (9) step();
    b2.in_valid = 1'b0;
    step(); step();
    check("h0_accepts", acc2.size() - base, 3);
    for (int i = base + 1; i < acc2.size(); i++) check("h0_gap", acc2[i] - acc2[i-1], 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
